// File: rtl/chip8_pkg.sv
// Shared types and constants for the CHIP-8 display path.
package chip8_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAW0,
    ST_DRAW1,
    ST_DONE,
    ST_CLEAR
  } state_t;

  localparam int SCREEN_W        = 64;
  localparam int SCREEN_H        = 32;
  localparam int MAX_SPRITE_ROWS = 15;

  localparam logic OP_DRAW  = 1'b0;
  localparam logic OP_CLEAR = 1'b1;

endpackage

// File: rtl/sprite_fetcher.sv
// Streams n sprite bytes out of main memory and packs them MSB-first
// into the GPU sprite bus; read data returns one cycle after the strobe.
module sprite_fetcher
  import chip8_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int MAX_ROWS = MAX_SPRITE_ROWS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [ADDR_W-1:0]     i_base,
  input  logic [3:0]            i_n,
  output logic                  o_rd_en,
  output logic [ADDR_W-1:0]     o_addr,
  input  logic [7:0]            i_rd_data,
  output logic [8*MAX_ROWS-1:0] o_sprite,
  output logic                  o_fetch_done
);

  localparam int SPR_W = 8 * MAX_ROWS;

  logic              r_rd_en;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_left;
  logic [3:0]        r_idx;
  logic              r_cap_en;
  logic              r_cap_last;
  logic [3:0]        r_cap_idx;
  logic [SPR_W-1:0]  r_sprite;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_en    <= 1'b0;
      r_addr     <= '0;
      r_left     <= '0;
      r_idx      <= '0;
      r_cap_en   <= 1'b0;
      r_cap_last <= 1'b0;
      r_cap_idx  <= '0;
      r_sprite   <= '0;
    end else if (i_start) begin
      // Clearing the whole bus here leaves rows >= n zero for the GPU.
      r_rd_en    <= (i_n != 4'd0);
      r_addr     <= i_base;
      r_left     <= i_n;
      r_idx      <= '0;
      r_cap_en   <= 1'b0;
      r_cap_last <= 1'b0;
      r_sprite   <= '0;
    end else begin
      r_cap_en   <= r_rd_en;
      r_cap_idx  <= r_idx;
      r_cap_last <= r_rd_en && (r_left == 4'd1);
      if (r_rd_en) begin
        r_addr <= r_addr + 1'b1;
        r_left <= r_left - 4'd1;
        r_idx  <= r_idx + 4'd1;
        if (r_left == 4'd1) r_rd_en <= 1'b0;
      end
      if (r_cap_en) begin
        for (int k = 0; k < MAX_ROWS; k++) begin
          if (r_cap_idx == 4'(k)) r_sprite[SPR_W-1-8*k -: 8] <= i_rd_data;
        end
      end
    end
  end

  assign o_rd_en      = r_rd_en;
  assign o_addr       = r_addr;
  assign o_sprite     = r_sprite;
  assign o_fetch_done = r_cap_en && r_cap_last;

endmodule

// File: rtl/gpu_draw_ctrl.sv
// Sequences CLS / DXYN commands from the CPU into GPU clear/draw strobes.
//   state    | meaning
//   IDLE     | ready for a command
//   FETCH    | sprite bytes being read from memory
//   DRAW0    | first gpu_draw cycle (GPU collision check)
//   DRAW1    | second gpu_draw cycle (GPU XOR), gpu_vf sampled
//   DONE     | one-cycle completion pulse
//   CLEAR    | one-cycle gpu_clear strobe
module gpu_draw_ctrl
  import chip8_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int MAX_ROWS = MAX_SPRITE_ROWS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_op,
  input  logic [7:0]            req_x,
  input  logic [7:0]            req_y,
  input  logic [3:0]            req_n,
  input  logic [ADDR_W-1:0]     req_i,
  output logic                  mem_rd_en,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [7:0]            mem_rd_data,
  output logic                  gpu_clear,
  output logic                  gpu_draw,
  output logic [7:0]            gpu_row,
  output logic [7:0]            gpu_col,
  output logic [7:0]            gpu_height,
  output logic [8*MAX_ROWS-1:0] gpu_sprite,
  input  logic [7:0]            gpu_vf,
  output logic                  done,
  output logic [7:0]            vf_out
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic       w_accept;
  logic       w_fetch_start;
  logic       w_fetch_done;
  logic [7:0] r_row;
  logic [7:0] r_col;
  logic [7:0] r_height;
  logic [7:0] r_vf;

  assign w_accept      = req_valid && (r_state == ST_IDLE);
  assign w_fetch_start = w_accept && (req_op == OP_DRAW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_op == OP_CLEAR)  w_state_nxt = ST_CLEAR;
          else if (req_n == 4'd0)  w_state_nxt = ST_DONE;
          else                     w_state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: if (w_fetch_done) w_state_nxt = ST_DRAW0;
      ST_DRAW0: w_state_nxt = ST_DRAW1;
      ST_DRAW1: w_state_nxt = ST_DONE;
      ST_CLEAR: w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row    <= '0;
      r_col    <= '0;
      r_height <= '0;
      r_vf     <= '0;
    end else begin
      if (w_accept) begin
        r_col    <= req_x & 8'(SCREEN_W - 1);
        r_row    <= req_y & 8'(SCREEN_H - 1);
        r_height <= {4'b0, req_n};
      end
      // An empty sprite cannot collide; a clear leaves VF alone.
      if (w_fetch_start && (req_n == 4'd0)) r_vf <= '0;
      else if (r_state == ST_DRAW1)         r_vf <= gpu_vf;
    end
  end

  sprite_fetcher #(
    .ADDR_W  (ADDR_W),
    .MAX_ROWS(MAX_ROWS)
  ) u_fetch (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (w_fetch_start),
    .i_base      (req_i),
    .i_n         (req_n),
    .o_rd_en     (mem_rd_en),
    .o_addr      (mem_addr),
    .i_rd_data   (mem_rd_data),
    .o_sprite    (gpu_sprite),
    .o_fetch_done(w_fetch_done)
  );

  assign req_ready  = (r_state == ST_IDLE);
  assign gpu_draw   = (r_state == ST_DRAW0) || (r_state == ST_DRAW1);
  assign gpu_clear  = (r_state == ST_CLEAR);
  assign done       = (r_state == ST_DONE);
  assign gpu_row    = r_row;
  assign gpu_col    = r_col;
  assign gpu_height = r_height;
  assign vf_out     = r_vf;

endmodule

// File: tb/tb_gpu_draw_ctrl.sv
// Scenario bench for gpu_draw_ctrl with a byte memory and a simple GPU VF model.
module tb_gpu_draw_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid, req_ready, req_op;
  logic [7:0]   req_x, req_y;
  logic [3:0]   req_n;
  logic [11:0]  req_i;
  logic         mem_rd_en;
  logic [11:0]  mem_addr;
  logic [7:0]   mem_rd_data;
  logic         gpu_clear, gpu_draw, done;
  logic [7:0]   gpu_row, gpu_col, gpu_height, gpu_vf, vf_out;
  logic [119:0] gpu_sprite;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [4096];
  logic [7:0] tb_vf;

  int          obs_rd_cyc[$];
  logic [11:0] obs_rd_addr[$];
  int          obs_draw_cyc[$];
  int          obs_clr_cyc[$];
  int          obs_done_cyc[$];
  logic [7:0]  obs_vf;
  logic        obs_ready_after;
  logic [119:0] obs_spr[2];
  logic [7:0]  obs_row[2], obs_col[2], obs_hgt[2];

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

  gpu_draw_ctrl #(.ADDR_W(12), .MAX_ROWS(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_x(req_x), .req_y(req_y), .req_n(req_n), .req_i(req_i),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .gpu_clear(gpu_clear), .gpu_draw(gpu_draw),
    .gpu_row(gpu_row), .gpu_col(gpu_col), .gpu_height(gpu_height),
    .gpu_sprite(gpu_sprite), .gpu_vf(gpu_vf),
    .done(done), .vf_out(vf_out)
  );

  function automatic logic [119:0] exp_sprite(input logic [11:0] base, input int n);
    logic [119:0] s = '0;
    for (int k = 0; k < n; k++) s[119-8*k -: 8] = mem[(int'(base) + k) % 4096];
    return s;
  endfunction

  // Issues one command and records what the DUT does over the following cycles.
  // Cycle c = number of rising edges since the accept edge.
  task automatic run_cmd(input logic op, input logic [7:0] x, input logic [7:0] y,
                         input logic [3:0] n, input logic [11:0] ia, input logic [7:0] vf);
    bit pend_vf = 0;
    obs_rd_cyc.delete(); obs_rd_addr.delete(); obs_draw_cyc.delete();
    obs_clr_cyc.delete(); obs_done_cyc.delete();
    obs_vf = 'x; obs_ready_after = 1'bx;
    for (int d = 0; d < 2; d++) begin
      obs_spr[d] = 'x; obs_row[d] = 'x; obs_col[d] = 'x; obs_hgt[d] = 'x;
    end
    gpu_vf = vf ^ 8'h01;
    req_op = op; req_x = x; req_y = y; req_n = n; req_i = ia; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op = 1'($urandom); req_x = 8'($urandom); req_y = 8'($urandom);
    req_n = 4'($urandom); req_i = 12'($urandom);
    for (int c = 1; c <= 24; c++) begin
      if (mem_rd_en) begin obs_rd_cyc.push_back(c); obs_rd_addr.push_back(mem_addr); end
      if (gpu_draw) begin
        if (obs_draw_cyc.size() < 2) begin
          obs_spr[obs_draw_cyc.size()] = gpu_sprite;
          obs_row[obs_draw_cyc.size()] = gpu_row;
          obs_col[obs_draw_cyc.size()] = gpu_col;
          obs_hgt[obs_draw_cyc.size()] = gpu_height;
        end
        if (obs_draw_cyc.size() == 0) pend_vf = 1;
        obs_draw_cyc.push_back(c);
      end
      if (gpu_clear) obs_clr_cyc.push_back(c);
      if (done) begin obs_done_cyc.push_back(c); obs_vf = vf_out; end
      if (obs_done_cyc.size() > 0 && c == obs_done_cyc[0] + 1) obs_ready_after = req_ready;
      @(posedge clk); #1;
      if (pend_vf) begin gpu_vf = vf; pend_vf = 0; end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++; if ({mem_rd_en, gpu_clear, gpu_draw, done} !== 4'b0000) begin
      errors++; $display("FAIL reset_strobes got=%b want=0000", {mem_rd_en, gpu_clear, gpu_draw, done}); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", req_ready); end
    checks++; if (mem_addr !== 12'h000) begin errors++; $display("FAIL reset_addr got=%h want=000", mem_addr); end
    checks++; if ({gpu_row, gpu_col, gpu_height} !== 24'h0) begin
      errors++; $display("FAIL reset_coords got=%h want=0", {gpu_row, gpu_col, gpu_height}); end
    checks++; if (gpu_sprite !== 120'h0) begin errors++; $display("FAIL reset_sprite got=%h want=0", gpu_sprite); end
    checks++; if (vf_out !== 8'h00) begin errors++; $display("FAIL reset_vf got=%h want=00", vf_out); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    tb_vf = 8'h00;
  endtask

  task automatic test_draw_font();
    bit ok;
    logic [7:0] font [5] = '{8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0};
    for (int k = 0; k < 5; k++) mem[12'h050 + k] = font[k];
    run_cmd(1'b0, 8'd3, 8'd5, 4'd5, 12'h050, 8'h00);
    ok = (obs_rd_cyc.size() == 5);
    for (int k = 0; k < 5 && ok; k++) ok = (obs_rd_cyc[k] == k + 1) && (obs_rd_addr[k] == 12'h050 + 12'(k));
    checks++; if (!ok) begin errors++; $display("FAIL font_reads got_n=%0d want=5 at 050..054 cycles 1..5", obs_rd_cyc.size()); end
    checks++; if (obs_spr[0] !== {40'hF0909090F0, 80'h0} || obs_spr[1] !== obs_spr[0]) begin
      errors++; $display("FAIL font_sprite got=%h want=%h", obs_spr[0], {40'hF0909090F0, 80'h0}); end
    checks++; if (!(obs_draw_cyc.size() == 2 && obs_draw_cyc[0] == 7 && obs_draw_cyc[1] == 8)) begin
      errors++; $display("FAIL font_draw_cycles got_n=%0d want=2 at 7,8", obs_draw_cyc.size()); end
    checks++; if (!(obs_done_cyc.size() == 1 && obs_done_cyc[0] == 9)) begin
      errors++; $display("FAIL font_done got_n=%0d want=1 at T+9", obs_done_cyc.size()); end
    checks++; if (obs_col[0] !== 8'd3 || obs_row[0] !== 8'd5 || obs_hgt[0] !== 8'd5) begin
      errors++; $display("FAIL font_coords got=%0d,%0d,%0d want=3,5,5", obs_col[0], obs_row[0], obs_hgt[0]); end
    checks++; if (obs_ready_after !== 1'b1 || obs_clr_cyc.size() != 0) begin
      errors++; $display("FAIL font_ready_after got=%b clr=%0d want=1,0", obs_ready_after, obs_clr_cyc.size()); end
    tb_vf = 8'h00;
  endtask

  task automatic test_vf();
    run_cmd(1'b0, 8'd10, 8'd2, 4'd3, 12'h200, 8'h01);
    tb_vf = 8'h01;
    checks++; if (obs_vf !== tb_vf || obs_done_cyc.size() != 1 || obs_done_cyc[0] != 7) begin
      errors++; $display("FAIL vf_collision got=%h want=%h", obs_vf, tb_vf); end
  endtask

  task automatic test_clear();
    run_cmd(1'b1, 8'd1, 8'd1, 4'd7, 12'h123, 8'h00);
    checks++; if (!(obs_clr_cyc.size() == 1 && obs_clr_cyc[0] == 1)) begin
      errors++; $display("FAIL clear_strobe got_n=%0d want=1 at T+1", obs_clr_cyc.size()); end
    checks++; if (!(obs_done_cyc.size() == 1 && obs_done_cyc[0] == 2)) begin
      errors++; $display("FAIL clear_done got_n=%0d want=1 at T+2", obs_done_cyc.size()); end
    checks++; if (obs_vf !== tb_vf) begin errors++; $display("FAIL clear_vf_held got=%h want=%h", obs_vf, tb_vf); end
    checks++; if (obs_ready_after !== 1'b1 || obs_draw_cyc.size() != 0 || obs_rd_cyc.size() != 0) begin
      errors++; $display("FAIL clear_quiet ready=%b draws=%0d reads=%0d want=1,0,0",
                         obs_ready_after, obs_draw_cyc.size(), obs_rd_cyc.size()); end
  endtask

  task automatic test_n0();
    run_cmd(1'b0, 8'd4, 8'd4, 4'd0, 12'h300, 8'h01);
    tb_vf = 8'h00;
    checks++; if (obs_rd_cyc.size() != 0 || obs_draw_cyc.size() != 0) begin
      errors++; $display("FAIL n0_quiet reads=%0d draws=%0d want=0,0", obs_rd_cyc.size(), obs_draw_cyc.size()); end
    checks++; if (!(obs_done_cyc.size() == 1 && obs_done_cyc[0] == 1) || obs_vf !== 8'h00) begin
      errors++; $display("FAIL n0_done got_n=%0d vf=%h want=1 at T+1 vf=00", obs_done_cyc.size(), obs_vf); end
  endtask

  task automatic test_coords_wrap();
    logic [11:0] want [4] = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
    bit ok;
    run_cmd(1'b0, 8'd70, 8'd40, 4'd1, 12'h010, 8'h00);
    checks++; if (obs_col[0] !== 8'd6 || obs_row[0] !== 8'd8) begin
      errors++; $display("FAIL coords_mod got=%0d,%0d want=6,8", obs_col[0], obs_row[0]); end
    run_cmd(1'b0, 8'd0, 8'd0, 4'd4, 12'hFFE, 8'h00);
    ok = (obs_rd_addr.size() == 4);
    for (int k = 0; k < 4 && ok; k++) ok = (obs_rd_addr[k] == want[k]);
    checks++; if (!ok) begin errors++; $display("FAIL addr_wrap got_n=%0d want=FFE,FFF,000,001", obs_rd_addr.size()); end
    checks++; if (obs_spr[0] !== exp_sprite(12'hFFE, 4)) begin
      errors++; $display("FAIL wrap_sprite got=%h want=%h", obs_spr[0], exp_sprite(12'hFFE, 4)); end
    tb_vf = 8'h00;
  endtask

  task automatic test_random_draws();
    for (int t = 0; t < 14; t++) begin
      logic [7:0] x = 8'($urandom), y = 8'($urandom), vf = 8'($urandom_range(0, 1));
      logic [3:0] n = 4'($urandom_range(0, 15));
      logic [11:0] ia = 12'($urandom);
      logic [119:0] es = exp_sprite(ia, int'(n));
      int edone = (n == 0) ? 1 : int'(n) + 4;
      bit ok;
      run_cmd(1'b0, x, y, n, ia, vf);
      tb_vf = (n == 0) ? 8'h00 : vf;
      ok = (obs_rd_cyc.size() == int'(n));
      for (int k = 0; k < int'(n) && ok; k++)
        ok = (obs_rd_cyc[k] == k + 1) && (obs_rd_addr[k] == 12'((int'(ia) + k) % 4096));
      checks++; if (!ok) begin errors++; $display("FAIL rnd%0d_reads got_n=%0d want=%0d from %h", t, obs_rd_cyc.size(), n, ia); end
      checks++; if (!(obs_done_cyc.size() == 1 && obs_done_cyc[0] == edone) || obs_vf !== tb_vf) begin
        errors++; $display("FAIL rnd%0d_done got_n=%0d vf=%h want=T+%0d vf=%h", t, obs_done_cyc.size(), obs_vf, edone, tb_vf); end
      if (n == 0) begin
        checks++; if (obs_draw_cyc.size() != 0) begin errors++; $display("FAIL rnd%0d_nodraw got=%0d want=0", t, obs_draw_cyc.size()); end
      end else begin
        checks++; if (!(obs_draw_cyc.size() == 2 && obs_draw_cyc[0] == n + 2 && obs_draw_cyc[1] == n + 3)) begin
          errors++; $display("FAIL rnd%0d_draw got_n=%0d want=2 at %0d", t, obs_draw_cyc.size(), n + 2); end
        checks++; if (obs_spr[0] !== es || obs_spr[1] !== es) begin
          errors++; $display("FAIL rnd%0d_sprite got=%h want=%h", t, obs_spr[1], es); end
        checks++; if (obs_col[1] !== (x % 64) || obs_row[1] !== (y % 32) || obs_hgt[1] !== 8'(n)) begin
          errors++; $display("FAIL rnd%0d_coords got=%0d,%0d,%0d want=%0d,%0d,%0d", t,
                             obs_col[1], obs_row[1], obs_hgt[1], x % 64, y % 32, n); end
      end
      checks++; if (obs_ready_after !== 1'b1) begin errors++; $display("FAIL rnd%0d_ready got=%b want=1", t, obs_ready_after); end
    end
  endtask

  task automatic test_reset_mid_fetch();
    int dones = 0;
    req_op = 1'b0; req_x = 8'd9; req_y = 8'd9; req_n = 4'd10; req_i = 12'h100; req_valid = 1'b1;
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (mem_rd_en !== 1'b1) begin errors++; $display("FAIL rst_fetch_active got=%b want=1", mem_rd_en); end
    #2 rst_n = 1'b0; #1;
    checks++; if ({mem_rd_en, gpu_draw, gpu_clear, done, req_ready} !== 5'b00001 || mem_addr !== 12'h000) begin
      errors++; $display("FAIL rst_async got=%b addr=%h want=00001 addr=000",
                         {mem_rd_en, gpu_draw, gpu_clear, done, req_ready}, mem_addr); end
    checks++; if (gpu_sprite !== 120'h0 || {gpu_row, gpu_col, gpu_height, vf_out} !== 32'h0) begin
      errors++; $display("FAIL rst_regs got=%h/%h want=0", gpu_sprite, {gpu_row, gpu_col, gpu_height, vf_out}); end
    for (int c = 0; c < 3; c++) begin @(posedge clk); #1; if (done) dones++; end
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 16; c++) begin @(posedge clk); #1; if (done) dones++; end
    checks++; if (dones != 0) begin errors++; $display("FAIL rst_no_done got=%0d want=0", dones); end
    tb_vf = 8'h00;
    run_cmd(1'b0, 8'd1, 8'd2, 4'd2, 12'h400, 8'h01);
    tb_vf = 8'h01;
    checks++; if (!(obs_done_cyc.size() == 1 && obs_done_cyc[0] == 6) || obs_spr[0] !== exp_sprite(12'h400, 2) || obs_vf !== tb_vf) begin
      errors++; $display("FAIL rst_recover done_n=%0d sprite=%h vf=%h want=T+6 %h %h",
                         obs_done_cyc.size(), obs_spr[0], obs_vf, exp_sprite(12'h400, 2), tb_vf); end
  endtask

  task automatic test_busy_hold();
    logic [7:0] acc_col[$], acc_hgt[$], got_col[$], got_hgt[$];
    int dones = 0;
    logic prev_draw = 1'b0;
    gpu_vf = 8'h00;
    req_valid = 1'b1; req_op = 1'b0;
    for (int c = 0; c < 110; c++) begin
      if (c < 80) begin
        req_x = 8'($urandom); req_y = 8'($urandom);
        req_n = 4'($urandom_range(1, 3)); req_i = 12'($urandom);
        if (req_ready) begin acc_col.push_back(req_x & 8'h3F); acc_hgt.push_back(8'(req_n)); end
      end else req_valid = 1'b0;
      if (done) dones++;
      if (gpu_draw && !prev_draw) begin got_col.push_back(gpu_col); got_hgt.push_back(gpu_height); end
      prev_draw = gpu_draw;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    checks++; if (dones != acc_col.size() || got_col.size() != acc_col.size() || dones < 8) begin
      errors++; $display("FAIL busy_count done=%0d draws=%0d accepts=%0d", dones, got_col.size(), acc_col.size()); end
    for (int k = 0; k < acc_col.size() && k < got_col.size(); k++) begin
      checks++; if (got_col[k] !== acc_col[k] || got_hgt[k] !== acc_hgt[k]) begin
        errors++; $display("FAIL busy_fields%0d got=%0d,%0d want=%0d,%0d", k, got_col[k], got_hgt[k], acc_col[k], acc_hgt[k]); end
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = 1'b0; req_x = '0; req_y = '0;
    req_n = '0; req_i = '0; gpu_vf = '0; tb_vf = '0;
    for (int k = 0; k < 4096; k++) mem[k] = 8'($urandom);
    test_reset();
    test_draw_font();
    test_vf();
    test_clear();
    test_n0();
    test_coords_wrap();
    test_random_draws();
    test_reset_mid_fetch();
    test_busy_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/gpu_draw_ctrl.md
# gpu_draw_ctrl

Sequencer between the CPU execute stage and the `gpu` framebuffer block. Accepts one display command at a time (CLS or DXYN), fetches sprite bytes from main memory, packs them into the GPU's 120-bit sprite bus, and drives the GPU's `clear`/`draw` strobes for the required cycle counts. Returns a one-cycle completion pulse with the collision flag to the CPU.

## Interface
- `ADDR_W`, 12, memory address width; addresses wrap modulo 2^ADDR_W.
- `MAX_ROWS`, 15, maximum sprite rows; fixes the sprite bus at 8*MAX_ROWS bits.

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  command valid.
- `req_ready`  out  1  controller idle; transfer when `req_valid && req_ready`.
- `req_op`  in  1  0 = DRAW (DXYN), 1 = CLEAR (00E0).
- `req_x`, `req_y`  in  8  Vx, Vy.
- `req_n`  in  4  sprite height n.
- `req_i`  in  ADDR_W  I register, address of sprite row 0.
- `mem_rd_en`  out  1  memory read strobe.
- `mem_addr`  out  ADDR_W  read address.
- `mem_rd_data`  in  8  read data, valid the cycle after `mem_rd_en`.
- `gpu_clear`, `gpu_draw`  out  1  GPU strobes.
- `gpu_row`, `gpu_col`, `gpu_height`  out  8  GPU start row, start col, height.
- `gpu_sprite`  out  8*MAX_ROWS  packed sprite bytes.
- `gpu_vf`  in  8  GPU collision flag.
- `done`  out  1  one-cycle completion pulse.
- `vf_out`  out  8  collision result, valid with `done` and held until the next DRAW completes.

## Operation
- States: IDLE, FETCH, DRAW0, DRAW1, DONE, CLEAR. `req_ready` = (state == IDLE).
- On accept, latch x, y, n, I, and op.
  - CLEAR op goes to CLEAR.
  - DRAW with n = 0 goes directly to DONE with `vf_out` = 0.
  - Otherwise DRAW goes to FETCH.
- FETCH:
  - Issue n reads back-to-back, one per cycle, at `(I + k) mod 2^ADDR_W` for k = 0..n-1.
  - Capture each returned byte into `gpu_sprite[8*MAX_ROWS-1-8k -: 8]`, so row 0 is the most significant byte.
  - Unused low bytes are zeroed at accept.
  - Leave FETCH the cycle after the last byte is captured.
- Coordinates:
  - `gpu_col` = x mod 64 (x & 8'h3F).
  - `gpu_row` = y mod 32 (y & 8'h1F).
  - `gpu_height` = {4'b0, n}.
  - No clipping is performed; clipping of off-screen rows and columns is the GPU's responsibility.
- DRAW0 and DRAW1 each hold `gpu_draw` = 1 for exactly one cycle, two consecutive cycles in total, matching the GPU's check-then-XOR sequence. Row, col, height, and sprite stay stable from DRAW0 through DRAW1.
- In DRAW1, sample `gpu_vf` into `vf_out`. The GPU updates VF at the end of DRAW0.
- CLEAR: `gpu_clear` = 1 for one cycle, then DONE. `vf_out` is unchanged.
- DONE: `done` = 1 for one cycle, then IDLE.
- `req_*` inputs are ignored outside IDLE.

## Timing
- Accept at cycle T.
  - DRAW with n ≥ 1:
    - reads issued at T+1..T+n;
    - last byte captured at T+n+1;
    - DRAW0 at T+n+2, DRAW1 at T+n+3;
    - `done` at T+n+4, so latency is n+4.
  - DRAW with n = 0: `done` at T+1.
  - CLEAR: `gpu_clear` at T+1, `done` at T+2.
- The earliest next accept is the cycle after `done`. Throughput is one command per n+5 cycles.
- `gpu_draw` is never asserted for more than 2 consecutive cycles, and never asserted in the same cycle as `gpu_clear`.
- Reset values:
  - state = IDLE, `req_ready` = 1.
  - `mem_rd_en`, `gpu_clear`, `gpu_draw`, `done` = 0.
  - `mem_addr`, `gpu_row`, `gpu_col`, `gpu_height`, `gpu_sprite`, `vf_out` = 0.
- Reset mid-operation: strobes drop immediately (asynchronous), and the in-flight command is discarded without `done`.
  - Reset between DRAW0 and DRAW1 leaves the GPU's internal draw phase at 1. The system-level reset must also reset the GPU; this block does not recover it.
- I wrap: I = 0xFFE, n = 4 reads 0xFFE, 0xFFF, 0x000, 0x001.

## Structure
- Shared package `chip8_pkg` holds:
  - state enum;
  - `SCREEN_W` = 64, `SCREEN_H` = 32, `MAX_SPRITE_ROWS` = 15;
  - `OP_DRAW` / `OP_CLEAR` encodings.
- One sub-module, `sprite_fetcher`, owns the read counter, the address increment/wrap, the 1-cycle data-return alignment, and the byte packing. It is handed start/I/n and signals `fetch_done`.
- The top-level FSM owns the handshake, the GPU strobes, and `vf_out`.

## Test plan
- CLEAR accepted at T → `gpu_clear` = 1 only at T+1, `done` at T+2, `vf_out` unchanged, `req_ready` = 1 at T+3.
- DRAW x = 3, y = 5, n = 5, I = 0x050, memory returns F0, 90, 90, 90, F0 →
  - reads at 0x050..0x054 on consecutive cycles;
  - `gpu_sprite[119:80]` = F0_90_90_90_F0, low bytes 0;
  - `gpu_draw` high exactly 2 cycles;
  - `done` at T+9.
- DRAW x = 70, y = 40 → `gpu_col` = 6, `gpu_row` = 8. DRAW with I = 0xFFE, n = 4 → addresses wrap to 0x000 and 0x001.
- DRAW with `gpu_vf` driven to 1 after DRAW0 → `vf_out` = 1 with `done`. DRAW with n = 0 → no reads, no `gpu_draw`, `done` at T+1, `vf_out` = 0.
- Assert `rst_n` low during FETCH → outputs return to reset values immediately, no `done`. A new request after release completes normally.
- Hold `req_valid` high with changing fields while busy → fields are ignored until IDLE, and exactly one command is accepted per `done`.
